// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: function codes, FSM states
// and small operand helpers.
package mdu_pkg;

   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1A;
   localparam logic [5:0] FUNC_DIVU  = 6'h1B;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mdu_state_t;

   function automatic logic is_muldiv(input logic [5:0] f);
      return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
   endfunction

   // Absolute value when treated as signed; 32'h8000_0000 maps to 2^31 unsigned.
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Operand/control bus between the execute stage and the multiply/divide unit.
interface mdu_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [5:0]  Func;
   logic        Start;
   logic        Flush;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   modport master (output A, B, Func, Start, Flush, input Busy, Done, Hi, Lo);
   modport slave  (input A, B, Func, Start, Flush, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/mdu_datapath.sv
// 64-bit accumulator/remainder shifter with a shared 33-bit add/subtract;
// one multiply or restoring-divide step per enabled cycle.
module mdu_datapath (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic        is_div,
   input  logic [31:0] load_val,
   input  logic [31:0] addend,
   output logic [63:0] acc
);

   logic [32:0] add_x;
   logic [32:0] add_y;
   logic [33:0] sum;
   logic [63:0] acc_next;

   // Divide subtracts from the remainder shifted left by one; sum[33] set means no borrow.
   always_comb begin
      add_x = is_div ? acc[63:31] : {1'b0, acc[63:32]};
      add_y = {1'b0, addend};
      sum   = {1'b0, add_x} + {1'b0, (is_div ? ~add_y : add_y)} + {33'd0, is_div};
      if (is_div)
         acc_next = sum[33] ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      else
         acc_next = acc[0] ? {sum[32:0], acc[31:1]} : {1'b0, acc[63:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (load)
         acc <= {32'd0, load_val};
      else if (step)
         acc <= acc_next;
   end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mdu
   import mdu_pkg::*;
(
   input  logic Clock,
   input  logic nReset,
   mdu_if.slave bus
);

   mdu_state_t  state, next_state;
   logic [4:0]  cnt;
   logic        load, step, wr_hilo, wr_hi, wr_lo;
   logic        op_div, neg_q, neg_r, div_zero;
   logic        a_sgn;
   logic [31:0] a_raw, a_mag, b_mag, hi_q, lo_q;
   logic [63:0] acc, prod;
   logic [31:0] quo, rem;

   // Signed variants are the even function codes.
   assign a_sgn = ~bus.Func[0];
   assign a_mag = magnitude(bus.A, a_sgn);

   mdu_datapath u_datapath (
      .clk      (Clock),
      .rst_n    (nReset),
      .load     (load),
      .step     (step),
      .is_div   (op_div),
      .load_val (a_mag),
      .addend   (b_mag),
      .acc      (acc)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      wr_hilo    = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Start && !bus.Flush) begin
               if (is_muldiv(bus.Func)) begin
                  load       = 1'b1;
                  next_state = RUN;
               end else if (bus.Func == FUNC_MTHI) begin
                  wr_hi = 1'b1;
               end else if (bus.Func == FUNC_MTLO) begin
                  wr_lo = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.Flush) begin
               next_state = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == '0)
                  next_state = FIX;
            end
         end
         FIX: begin
            if (bus.Flush) begin
               next_state = IDLE;
            end else begin
               wr_hilo    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: next_state = IDLE;
      endcase
   end

   always_comb begin
      prod = neg_q ? (64'd0 - acc) : acc;
      quo  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
      rem  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         cnt      <= '0;
         op_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         a_raw    <= '0;
         b_mag    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         if (load) begin
            cnt      <= 5'd31;
            op_div   <= bus.Func[1];
            neg_q    <= a_sgn & (bus.A[31] ^ bus.B[31]);
            neg_r    <= a_sgn & bus.A[31];
            div_zero <= (bus.B == '0);
            a_raw    <= bus.A;
            b_mag    <= magnitude(bus.B, a_sgn);
         end else if (step && cnt != '0) begin
            cnt <= cnt - 5'd1;
         end
         if (wr_hi)
            hi_q <= bus.A;
         if (wr_lo)
            lo_q <= bus.A;
         if (wr_hilo) begin
            if (!op_div) begin
               {hi_q, lo_q} <= prod;
            end else if (div_zero) begin
               hi_q <= a_raw;
               lo_q <= '1;
            end else begin
               hi_q <= rem;
               lo_q <= quo;
            end
         end
      end
   end

   assign bus.Busy = (state == RUN) || (state == FIX);
   assign bus.Done = (state == DONE);
   assign bus.Hi   = hi_q;
   assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_mdu;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic n_reset;
   always #5 clk = ~clk;

   mdu_if bus();

   mdu dut (
      .Clock  (clk),
      .nReset (n_reset),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_hi, exp_lo;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb;
      int     qa, qb;
      case (f)
         FUNC_MULTU: return {32'd0, a} * {32'd0, b};
         FUNC_MULT: begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
         end
         FUNC_DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         FUNC_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            qa = a;
            qb = b;
            return {32'(qa % qb), 32'(qa / qb)};
         end
         default: return '0;
      endcase
   endfunction

   task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.Func  = f;
      bus.A     = a;
      bus.B     = b;
      bus.Start = 1'b1;
      @(posedge clk);
      #1 bus.Start = 1'b0;
   endtask

   // Counts busy cycles; returns while sitting in the first non-busy cycle.
   task automatic wait_done(output int busy_n, output logic hi_stable);
      logic [31:0] h0;
      h0        = bus.Hi;
      busy_n    = 0;
      hi_stable = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.Busy) break;
         busy_n++;
         if (bus.Hi !== h0) hi_stable = 1'b0;
      end
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      int          n;
      logic        stable;
      logic [63:0] r;
      r = ref_result(f, a, b);
      drive(f, a, b);
      wait_done(n, stable);
      check({tag, "_busy_cycles"}, n, 33);
      check({tag, "_done"}, bus.Done, 1);
      check({tag, "_hi_held"}, stable, 1);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check({tag, "_hi"}, bus.Hi, exp_hi);
      check({tag, "_lo"}, bus.Lo, exp_lo);
      bus.Func  = FUNC_MULTU;
      bus.Start = 1'b1;
      @(posedge clk);
      #1 bus.Start = 1'b0;
      @(negedge clk);
      check({tag, "_start_in_done_ignored"}, bus.Busy, 0);
      check({tag, "_done_single"}, bus.Done, 0);
   endtask

   task automatic mt_write(input logic [5:0] f, input logic [31:0] a, input logic flush);
      @(negedge clk);
      bus.Func  = f;
      bus.A     = a;
      bus.Start = 1'b1;
      bus.Flush = flush;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      if (!flush) begin
         if (f == FUNC_MTHI) exp_hi = a;
         else exp_lo = a;
      end
      @(negedge clk);
      check("mt_hi", bus.Hi, exp_hi);
      check("mt_lo", bus.Lo, exp_lo);
      check("mt_busy", bus.Busy, 0);
      check("mt_done", bus.Done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : main
      int          n;
      logic        st;
      logic        seen_done;
      logic [63:0] r;

      n_reset   = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Func  = '0;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      exp_hi    = '0;
      exp_lo    = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.Busy, 0);
      check("rst_done", bus.Done, 0);
      check("rst_hi", bus.Hi, 0);
      check("rst_lo", bus.Lo, 0);
      n_reset = 1'b1;

      run_op("multu_7x6", FUNC_MULTU, 32'd7, 32'd6);
      run_op("multu_max", FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mult_max", FUNC_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div_m7_2", FUNC_DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("divu_by0", FUNC_DIVU, 32'd7, 32'd0);
      run_op("div_by0_neg", FUNC_DIV, 32'hFFFF_FF00, 32'd0);
      run_op("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("mult_minint", FUNC_MULT, 32'h8000_0000, 32'd3);

      // MTHI, then a MULTU with a second Start while busy.
      mt_write(FUNC_MTHI, 32'hDEAD_BEEF, 1'b0);
      r = ref_result(FUNC_MULTU, 32'h0001_2345, 32'h0000_0100);
      drive(FUNC_MULTU, 32'h0001_2345, 32'h0000_0100);
      repeat (9) @(negedge clk);
      check("retrig_hi_before", bus.Hi, 32'hDEAD_BEEF);
      bus.Func  = FUNC_DIVU;
      bus.A     = 32'd1;
      bus.B     = 32'd1;
      bus.Start = 1'b1;
      @(posedge clk);
      #1 bus.Start = 1'b0;
      wait_done(n, st);
      check("retrig_busy_cycles", 9 + n, 33);
      check("retrig_hi_held", st, 1);
      check("retrig_done", bus.Done, 1);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check("retrig_hi", bus.Hi, exp_hi);
      check("retrig_lo", bus.Lo, exp_lo);
      @(negedge clk);
      check("retrig_not_queued", bus.Busy, 0);

      // Flush mid-DIV leaves HI/LO untouched and suppresses Done.
      mt_write(FUNC_MTHI, 32'h1234_5678, 1'b0);
      mt_write(FUNC_MTLO, 32'h1234_5678, 1'b0);
      drive(FUNC_DIV, 32'd100, 32'd7);
      repeat (14) @(negedge clk);
      bus.Flush = 1'b1;
      @(posedge clk);
      #1 bus.Flush = 1'b0;
      @(negedge clk);
      check("flush_busy", bus.Busy, 0);
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.Done) seen_done = 1'b1;
      end
      check("flush_no_done", seen_done, 0);
      check("flush_hi", bus.Hi, 32'h1234_5678);
      check("flush_lo", bus.Lo, 32'h1234_5678);

      // Flush in IDLE blocks same-cycle MTHI and mul/div issue.
      mt_write(FUNC_MTHI, 32'hAAAA_5555, 1'b1);
      @(negedge clk);
      bus.Func  = FUNC_MULTU;
      bus.Start = 1'b1;
      bus.Flush = 1'b1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      @(negedge clk);
      check("idle_flush_blocks_start", bus.Busy, 0);

      // Asynchronous reset mid-MULT.
      drive(FUNC_MULT, 32'hFFFF_FFF3, 32'h0000_0123);
      repeat (19) @(negedge clk);
      #2 n_reset = 1'b0;
      #1;
      check("arst_busy", bus.Busy, 0);
      check("arst_done", bus.Done, 0);
      check("arst_hi", bus.Hi, 0);
      check("arst_lo", bus.Lo, 0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      n_reset = 1'b1;
      run_op("multu_3x5", FUNC_MULTU, 32'd3, 32'd5);

      for (int i = 0; i < 20; i++) begin : rnd
         logic [5:0]  f;
         logic [31:0] a, b;
         int          k;
         k = $urandom_range(0, 7);
         f = FUNC_MULT + 6'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         if (k == 0) begin
            b = '0;
         end else if (k == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (k == 2) begin
            a = $urandom_range(0, 1000);
            b = $urandom_range(1, 20);
         end else if (k == 3) begin
            mt_write(($urandom_range(0, 1) == 1) ? FUNC_MTHI : FUNC_MTLO, a, 1'b0);
         end
         run_op("rand", f, a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
